// File: rtl/ascon_aead_core.sv
`default_nettype none
// ============================================================================
// Module      : ascon_aead_core
// Description : Ascon-AEAD128 engine with runtime AD/data block counts,
//               encrypt/decrypt with on-chip tag check, 1/2/4 rounds per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_aead_core #(
    parameter int UNROLL = 1,
    parameter int CNT_W  = 8
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic             decrypt_i,
    input  logic [127:0]     key_i,
    input  logic [127:0]     nonce_i,
    input  logic [127:0]     tag_i,
    input  logic [CNT_W-1:0] nb_ad_i,
    input  logic [CNT_W-1:0] nb_data_i,
    input  logic [127:0]     data_i,
    input  logic             data_valid_i,
    output logic             data_ready_o,
    output logic [127:0]     data_o,
    output logic             data_valid_o,
    output logic [127:0]     tag_o,
    output logic             tag_valid_o,
    output logic             auth_ok_o,
    output logic             busy_o
);

    localparam logic [63:0]  c_iv       = 64'h00001000808c0001;
    localparam logic [127:0] c_pad_full = 128'h1;

    localparam logic [3:0] c_st_idle        = 4'd0;
    localparam logic [3:0] c_st_init        = 4'd1;
    localparam logic [3:0] c_st_ad_wait     = 4'd2;
    localparam logic [3:0] c_st_ad_perm     = 4'd3;
    localparam logic [3:0] c_st_ad_pad_perm = 4'd4;
    localparam logic [3:0] c_st_domsep      = 4'd5;
    localparam logic [3:0] c_st_data_wait   = 4'd6;
    localparam logic [3:0] c_st_data_perm   = 4'd7;
    localparam logic [3:0] c_st_final       = 4'd8;
    localparam logic [3:0] c_st_tag         = 4'd9;
    localparam logic [3:0] c_st_done        = 4'd10;

    logic [3:0]       r_fsm;
    logic [3:0]       w_fsm_next;
    logic [319:0]     r_state;
    logic [3:0]       r_rnd;
    logic [CNT_W-1:0] r_ad_cnt;
    logic [CNT_W-1:0] r_data_cnt;
    logic             r_decrypt;
    logic [127:0]     r_key;
    logic [127:0]     r_tag_exp;

    logic             w_ready;
    logic             w_hs;
    logic [3:0]       w_rnd_next;
    logic             w_perm_last;
    logic [319:0]     w_perm_out;
    logic [319:0]     w_dom;
    logic [127:0]     w_tag;
    logic [319:0]     w_chain [0:UNROLL];

    function automatic logic [63:0] f_ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One Ascon round; word xN lives at state[64*N +: 64], idx is the 0..11 round number of p^12.
    function automatic logic [319:0] f_round(input logic [319:0] s, input logic [3:0] idx);
        logic [63:0] x0, x1, x2, x3, x4;
        logic [63:0] t0, t1, t2, t3, t4;
        x0 = s[63:0];
        x1 = s[127:64];
        x2 = s[191:128];
        x3 = s[255:192];
        x4 = s[319:256];
        x2 = x2 ^ {56'd0, 4'hf - idx, idx};
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ f_ror(x0, 19) ^ f_ror(x0, 28);
        x1 = x1 ^ f_ror(x1, 61) ^ f_ror(x1, 39);
        x2 = x2 ^ f_ror(x2, 1)  ^ f_ror(x2, 6);
        x3 = x3 ^ f_ror(x3, 10) ^ f_ror(x3, 17);
        x4 = x4 ^ f_ror(x4, 7)  ^ f_ror(x4, 41);
        return {x4, x3, x2, x1, x0};
    endfunction

    function automatic logic [319:0] f_key_cap(input logic [319:0] s, input logic [127:0] k);
        return {s[319:256], s[255:128] ^ k, s[127:0]};
    endfunction

    function automatic logic [319:0] f_final_entry(input logic [319:0] s, input logic [127:0] k);
        return f_key_cap(s, k) ^ {192'd0, c_pad_full};
    endfunction

    // Round counter runs up to 12 for both p^a (from 0) and p^b (from 4).
    assign w_chain[0] = r_state;
    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        assign w_chain[g+1] = f_round(w_chain[g], r_rnd + 4'(g));
    end
    assign w_perm_out  = w_chain[UNROLL];
    assign w_rnd_next  = r_rnd + 4'(UNROLL);
    assign w_perm_last = (w_rnd_next == 4'd12);
    assign w_dom       = r_state ^ 320'd1;
    assign w_tag       = r_state[319:192] ^ r_key;
    assign w_hs        = w_ready & data_valid_i;
    assign data_ready_o = w_ready;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_fsm <= c_st_idle;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            c_st_idle:        if (start_i) w_fsm_next = c_st_init;
            c_st_init:        if (w_perm_last)
                                  w_fsm_next = (r_ad_cnt != '0) ? c_st_ad_wait : c_st_domsep;
            c_st_ad_wait:     if (w_hs) w_fsm_next = c_st_ad_perm;
            c_st_ad_perm:     if (w_perm_last)
                                  w_fsm_next = (r_ad_cnt != '0) ? c_st_ad_wait : c_st_ad_pad_perm;
            c_st_ad_pad_perm: if (w_perm_last) w_fsm_next = c_st_domsep;
            c_st_domsep:      w_fsm_next = (r_data_cnt != '0) ? c_st_data_wait : c_st_final;
            c_st_data_wait:   if (w_hs) w_fsm_next = c_st_data_perm;
            c_st_data_perm:   if (w_perm_last)
                                  w_fsm_next = (r_data_cnt != '0) ? c_st_data_wait : c_st_final;
            c_st_final:       if (w_perm_last) w_fsm_next = c_st_tag;
            c_st_tag:         w_fsm_next = c_st_done;
            c_st_done:        w_fsm_next = c_st_idle;
            default:          w_fsm_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_ready = (r_fsm == c_st_ad_wait) || (r_fsm == c_st_data_wait);
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_state      <= '0;
            r_rnd        <= '0;
            r_ad_cnt     <= '0;
            r_data_cnt   <= '0;
            r_decrypt    <= 1'b0;
            r_key        <= '0;
            r_tag_exp    <= '0;
            data_o       <= '0;
            data_valid_o <= 1'b0;
            tag_o        <= '0;
            tag_valid_o  <= 1'b0;
            auth_ok_o    <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            data_valid_o <= 1'b0;
            tag_valid_o  <= 1'b0;
            case (r_fsm)
                c_st_idle: begin
                    if (start_i) begin
                        r_state    <= {c_iv, key_i, nonce_i};
                        r_key      <= key_i;
                        r_tag_exp  <= tag_i;
                        r_decrypt  <= decrypt_i;
                        r_ad_cnt   <= nb_ad_i;
                        r_data_cnt <= nb_data_i;
                        r_rnd      <= 4'd0;
                        auth_ok_o  <= 1'b0;
                        busy_o     <= 1'b1;
                    end
                end
                c_st_init: begin
                    r_rnd   <= w_rnd_next;
                    r_state <= w_perm_last ? f_key_cap(w_perm_out, r_key) : w_perm_out;
                end
                c_st_ad_wait: begin
                    if (w_hs) begin
                        r_state[127:0] <= r_state[127:0] ^ data_i;
                        r_ad_cnt       <= r_ad_cnt - CNT_W'(1);
                        r_rnd          <= 4'd4;
                    end
                end
                c_st_ad_perm: begin
                    r_rnd   <= w_perm_last ? 4'd4 : w_rnd_next;
                    r_state <= (w_perm_last && r_ad_cnt == '0) ?
                               (w_perm_out ^ {192'd0, c_pad_full}) : w_perm_out;
                end
                c_st_domsep: begin
                    r_rnd   <= 4'd0;
                    r_state <= (r_data_cnt == '0) ? f_final_entry(w_dom, r_key) : w_dom;
                end
                c_st_data_wait: begin
                    if (w_hs) begin
                        // Decrypt feeds the ciphertext back into the rate.
                        r_state[127:0] <= r_decrypt ? data_i : (r_state[127:0] ^ data_i);
                        r_data_cnt     <= r_data_cnt - CNT_W'(1);
                        r_rnd          <= 4'd4;
                        data_o         <= r_state[127:0] ^ data_i;
                        data_valid_o   <= 1'b1;
                    end
                end
                c_st_data_perm: begin
                    r_rnd   <= (w_perm_last && r_data_cnt == '0) ? 4'd0 : w_rnd_next;
                    r_state <= (w_perm_last && r_data_cnt == '0) ?
                               f_final_entry(w_perm_out, r_key) : w_perm_out;
                end
                c_st_ad_pad_perm, c_st_final: begin
                    r_rnd   <= w_rnd_next;
                    r_state <= w_perm_out;
                end
                c_st_tag: begin
                    tag_o       <= w_tag;
                    tag_valid_o <= 1'b1;
                    auth_ok_o   <= r_decrypt && (w_tag == r_tag_exp);
                end
                c_st_done: begin
                    busy_o <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ascon_aead_core.sv
`default_nettype none
// Directed bench for ascon_aead_core: three instances (UNROLL 1/2/4) checked
// against a column-S-box software model and hand-derived latencies.
module tb_ascon_aead_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         resetb;
    logic         start [3];
    logic         dvi   [3];
    logic         dec_in;
    logic [127:0] key_in, nonce_in, tag_in, data_in;
    logic [7:0]   nad_in, nd_in;
    logic         rdy [3], dvo [3], tvo [3], aok [3], bsy [3];
    logic [127:0] dout [3], tago [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int U = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        ascon_aead_core #(.UNROLL(U), .CNT_W(8)) u_dut (
            .clock_i     (clk),
            .resetb_i    (resetb),
            .start_i     (start[g]),
            .decrypt_i   (dec_in),
            .key_i       (key_in),
            .nonce_i     (nonce_in),
            .tag_i       (tag_in),
            .nb_ad_i     (nad_in),
            .nb_data_i   (nd_in),
            .data_i      (data_in),
            .data_valid_i(dvi[g]),
            .data_ready_o(rdy[g]),
            .data_o      (dout[g]),
            .data_valid_o(dvo[g]),
            .tag_o       (tago[g]),
            .tag_valid_o (tvo[g]),
            .auth_ok_o   (aok[g]),
            .busy_o      (bsy[g])
        );
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_val(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [4:0] m_sbox(input logic [4:0] i);
        case (i)
            5'd0:  return 5'h04;  5'd1:  return 5'h0b;  5'd2:  return 5'h1f;  5'd3:  return 5'h14;
            5'd4:  return 5'h1a;  5'd5:  return 5'h15;  5'd6:  return 5'h09;  5'd7:  return 5'h02;
            5'd8:  return 5'h1b;  5'd9:  return 5'h05;  5'd10: return 5'h08;  5'd11: return 5'h12;
            5'd12: return 5'h1d;  5'd13: return 5'h03;  5'd14: return 5'h06;  5'd15: return 5'h1c;
            5'd16: return 5'h1e;  5'd17: return 5'h13;  5'd18: return 5'h07;  5'd19: return 5'h0e;
            5'd20: return 5'h00;  5'd21: return 5'h0d;  5'd22: return 5'h11;  5'd23: return 5'h18;
            5'd24: return 5'h10;  5'd25: return 5'h0c;  5'd26: return 5'h01;  5'd27: return 5'h19;
            5'd28: return 5'h16;  5'd29: return 5'h0a;  5'd30: return 5'h0f;  default: return 5'h17;
        endcase
    endfunction

    function automatic logic [63:0] m_ror(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    function automatic logic [319:0] m_perm(input logic [319:0] s, input int nr);
        logic [63:0] x [5];
        logic [4:0]  o;
        for (int i = 0; i < 5; i++) x[i] = s[64*i +: 64];
        for (int r = 12 - nr; r < 12; r++) begin
            x[2] = x[2] ^ 64'(((15 - r) << 4) | r);
            for (int b = 0; b < 64; b++) begin
                o = m_sbox({x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]});
                x[0][b] = o[4]; x[1][b] = o[3]; x[2][b] = o[2]; x[3][b] = o[1]; x[4][b] = o[0];
            end
            x[0] = x[0] ^ m_ror(x[0], 19) ^ m_ror(x[0], 28);
            x[1] = x[1] ^ m_ror(x[1], 61) ^ m_ror(x[1], 39);
            x[2] = x[2] ^ m_ror(x[2], 1)  ^ m_ror(x[2], 6);
            x[3] = x[3] ^ m_ror(x[3], 10) ^ m_ror(x[3], 17);
            x[4] = x[4] ^ m_ror(x[4], 7)  ^ m_ror(x[4], 41);
        end
        return {x[4], x[3], x[2], x[1], x[0]};
    endfunction

    logic [127:0] blk     [16];
    logic [127:0] got_blk [16];
    logic [127:0] mdl_blk [16];

    task automatic model_run(input bit dec, input logic [127:0] k, n, input int nad, nd,
                             output logic [127:0] tag);
        logic [319:0] s;
        s = m_perm({64'h00001000808c0001, k, n}, 12);
        s[255:128] = s[255:128] ^ k;
        if (nad > 0) begin
            for (int i = 0; i < nad; i++) begin
                s[127:0] = s[127:0] ^ blk[i];
                s = m_perm(s, 8);
            end
            s[127:0] = s[127:0] ^ 128'h1;
            s = m_perm(s, 8);
        end
        s[0] = ~s[0];
        for (int i = 0; i < nd; i++) begin
            mdl_blk[i] = s[127:0] ^ blk[nad+i];
            s[127:0] = dec ? blk[nad+i] : mdl_blk[i];
            s = m_perm(s, 8);
        end
        s[127:0]   = s[127:0] ^ 128'h1;
        s[255:128] = s[255:128] ^ k;
        s = m_perm(s, 12);
        tag = s[319:192] ^ k;
    endtask

    function automatic int lat_exp(input int u, nad, nd);
        return 1 + 12/u + ((nad > 0) ? (nad*(1 + 8/u) + 8/u) : 0) + 1 + nd*(1 + 8/u) + 12/u + 1;
    endfunction

    // ---------------- transaction driver ----------------
    int           res_hs, res_dv, res_lat;
    bit           res_ready, res_busy_ok;
    logic [127:0] res_tag;
    logic         res_auth;

    task automatic run_op(input int idx, input bit dec, input logic [127:0] k, n, t,
                          input int nad, nd, input bit gaps, midstart, do_rst);
        int cyc, hs_cyc;
        bit done, timeout, v, quiet_bad;
        res_hs = 0; res_dv = 0; res_lat = -1; res_ready = 0; res_busy_ok = 0;
        res_tag = '0; res_auth = 1'b0;
        done = 0; timeout = 0; hs_cyc = -100;
        @(negedge clk);
        dec_in = dec; key_in = k; nonce_in = n; tag_in = t;
        nad_in = 8'(nad); nd_in = 8'(nd);
        start[idx] = 1'b1; dvi[idx] = 1'b0;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start[idx] = 1'b0;
        dec_in = ~dec; key_in = ~k; nonce_in = ~n; tag_in = ~t; nad_in = 8'hff; nd_in = 8'hff;
        while (!done && !timeout) begin
            if (dvo[idx]) begin
                got_blk[res_dv & 15] = dout[idx];
                res_dv++;
            end
            if (rdy[idx]) res_ready = 1;
            if (tvo[idx]) begin
                res_lat = cyc; res_tag = tago[idx]; res_auth = aok[idx]; res_busy_ok = bsy[idx];
                done = 1;
            end else if (do_rst && res_hs == nad + 1 && cyc == hs_cyc + 3) begin
                resetb = 1'b0;
                #1;
                check_val("rst_busy", 128'(bsy[idx]), 128'd0);
                check_val("rst_ctl", 128'({rdy[idx], dvo[idx], tvo[idx], aok[idx]}), 128'd0);
                check_val("rst_data", dout[idx], 128'd0);
                check_val("rst_tag", tago[idx], 128'd0);
                @(negedge clk);
                resetb = 1'b1;
                quiet_bad = 0;
                for (int i = 0; i < 20; i++) begin
                    @(negedge clk);
                    if (dvo[idx] || tvo[idx] || bsy[idx]) quiet_bad = 1;
                end
                check_val("rst_quiet", 128'(quiet_bad), 128'd0);
                done = 1;
            end else begin
                v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                dvi[idx] = v;
                data_in = blk[res_hs & 15];
                start[idx] = midstart && (cyc == 6);
                if (rdy[idx] && v) begin
                    res_hs++;
                    hs_cyc = cyc;
                end
                @(posedge clk);
                cyc++;
                @(negedge clk);
                if (cyc > 3000) timeout = 1;
            end
        end
        dvi[idx] = 1'b0; start[idx] = 1'b0;
        check_val("timeout", 128'(timeout), 128'd0);
        if (do_rst) check_val("rst_hit", 128'(done), 128'd1);
        if (!do_rst && done) begin
            @(negedge clk);
            res_busy_ok = res_busy_ok && !bsy[idx] && !tvo[idx];
        end
    endtask

    task automatic check_blocks(input string nm, input int nd);
        check_val({nm, "_ndv"}, 128'(res_dv), 128'(nd));
        for (int i = 0; i < nd; i++) check_val({nm, "_data"}, got_blk[i], mdl_blk[i]);
    endtask

    logic [127:0] ct1, tag1, etag, k6, n6, tag6;
    logic [127:0] pt6 [4];
    logic [127:0] ct6 [4];

    initial begin
        for (int i = 0; i < 3; i++) begin start[i] = 1'b0; dvi[i] = 1'b0; end
        dec_in = 0; key_in = '0; nonce_in = '0; tag_in = '0; data_in = '0; nad_in = '0; nd_in = '0;
        for (int i = 0; i < 16; i++) blk[i] = '0;
        resetb = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_val("reset_ctl", 128'({bsy[i], rdy[i], dvo[i], tvo[i], aok[i]}), 128'd0);
            check_val("reset_data", dout[i] | tago[i], 128'd0);
        end
        resetb = 1'b1;

        // all-zero encrypt, one AD and one data block
        model_run(0, '0, '0, 1, 1, etag);
        run_op(0, 0, '0, '0, '0, 1, 1, 0, 0, 0);
        check_blocks("enc0", 1);
        check_val("enc0_tag", res_tag, etag);
        check_val("enc0_lat", 128'(res_lat), 128'd53);
        check_val("enc0_hs", 128'(res_hs), 128'd2);
        check_val("enc0_auth", 128'(res_auth), 128'd0);
        check_val("enc0_busy", 128'(res_busy_ok), 128'd1);
        ct1 = got_blk[0]; tag1 = res_tag;

        // round trip with the matching and a corrupted tag
        blk[1] = ct1;
        run_op(0, 1, '0, '0, tag1, 1, 1, 0, 0, 0);
        check_val("dec_pt", got_blk[0], 128'd0);
        check_val("dec_auth", 128'(res_auth), 128'd1);
        check_val("dec_tag", res_tag, tag1);
        run_op(0, 1, '0, '0, tag1 ^ 128'd1, 1, 1, 0, 0, 0);
        check_val("badtag_pt", got_blk[0], 128'd0);
        check_val("badtag_auth", 128'(res_auth), 128'd0);

        // zero-count cases
        key_in = '0;
        k6 = {$urandom, $urandom, $urandom, $urandom};
        n6 = {$urandom, $urandom, $urandom, $urandom};
        model_run(0, k6, n6, 0, 0, etag);
        run_op(0, 0, k6, n6, '0, 0, 0, 0, 0, 0);
        check_val("z00_ready", 128'(res_ready), 128'd0);
        check_val("z00_tag", res_tag, etag);
        check_val("z00_lat", 128'(res_lat), 128'd27);
        for (int i = 0; i < 3; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
        model_run(0, k6, n6, 3, 0, etag);
        run_op(0, 0, k6, n6, '0, 3, 0, 0, 0, 0);
        check_val("z30_hs", 128'(res_hs), 128'd3);
        check_val("z30_tag", res_tag, etag);
        check_val("z30_lat", 128'(res_lat), 128'd62);

        // random vectors on every unroll factor
        for (int i = 0; i < 6; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) pt6[i] = blk[2+i];
        model_run(0, k6, n6, 2, 4, tag6);
        for (int i = 0; i < 4; i++) ct6[i] = mdl_blk[i];
        for (int u = 0; u < 3; u++) begin
            run_op(u, 0, k6, n6, '0, 2, 4, 0, 0, 0);
            check_blocks("unr", 4);
            check_val("unr_tag", res_tag, tag6);
            check_val("unr_lat", 128'(res_lat), 128'(lat_exp(1 << u, 2, 4)));
            check_val("unr_hs", 128'(res_hs), 128'd6);
        end

        // back-pressure on UNROLL=2
        run_op(1, 0, k6, n6, '0, 2, 4, 1, 0, 0);
        check_blocks("gap", 4);
        check_val("gap_tag", res_tag, tag6);

        // decrypt on UNROLL=4 recovers the plaintext
        for (int i = 0; i < 4; i++) blk[2+i] = ct6[i];
        run_op(2, 1, k6, n6, tag6, 2, 4, 0, 0, 0);
        for (int i = 0; i < 4; i++) check_val("dec4_pt", got_blk[i], pt6[i]);
        check_val("dec4_auth", 128'(res_auth), 128'd1);
        for (int i = 0; i < 4; i++) blk[2+i] = pt6[i];

        // reset during DATA_PERM, then a clean run
        run_op(0, 0, k6, n6, '0, 2, 4, 0, 0, 1);
        model_run(0, k6, n6, 2, 4, tag6);
        run_op(0, 0, k6, n6, '0, 2, 4, 0, 0, 0);
        check_blocks("post_rst", 4);
        check_val("post_rst_tag", res_tag, tag6);

        // start pulse while busy is ignored
        run_op(0, 0, k6, n6, '0, 2, 4, 0, 1, 0);
        check_blocks("midst", 4);
        check_val("midst_tag", res_tag, tag6);
        check_val("midst_lat", 128'(res_lat), 128'(lat_exp(1, 2, 4)));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ascon_aead_core.md
# ascon_aead_core

Parametrised Ascon-AEAD128 engine covering one full authenticated encryption or decryption per `start_i`. It runs initialisation, a variable number of associated-data (AD) blocks, a variable number of data blocks and finalisation, using a valid/ready handshake on the data stream. Compared with the fixed single-AD, single-round-per-cycle top it replaces, it adds:

- runtime block counts;
- a decrypt mode with on-chip tag check;
- a configurable number of permutation rounds per cycle.

It sits directly under the system integration level and reuses the round function from `ascon_pack`.

## Interface

Parameters:
- `UNROLL`, default 1: permutation rounds per cycle; legal values are 1, 2 and 4.
- `CNT_W`, default 8: width of the AD and data block counters.

Ports:
- `clock_i` in 1: the single clock.
- `resetb_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: start request; sampled only in IDLE.
- `decrypt_i` in 1: 0 = encrypt, 1 = decrypt; latched at start.
- `key_i` in 128, `nonce_i` in 128: latched at start.
- `tag_i` in 128: expected tag, used in decrypt; latched at start.
- `nb_ad_i` in `CNT_W`, `nb_data_i` in `CNT_W`: block counts, latched at start; 0 is legal.
- `data_i` in 128: AD block or plaintext/ciphertext block.
- `data_valid_i` in 1: `data_i` valid.
- `data_ready_o` out 1: core accepts a block on this edge.
- `data_o` out 128: ciphertext (encrypt) or plaintext (decrypt).
- `data_valid_o` out 1: one-cycle pulse qualifying `data_o`.
- `tag_o` out 128: computed tag.
- `tag_valid_o` out 1: one-cycle pulse.
- `auth_ok_o` out 1: in decrypt, `tag_o == tag_i`; held until next start. Always 0 in encrypt.
- `busy_o` out 1: high from the start edge until DONE exits.

## Operation

- All blocks are full 128-bit blocks. Partial-block padding and truncation belong to the caller. The core inserts the full-block padding constant `PAD_FULL` from `ascon_pack` after the last AD block and after the last data block.
- The state is 320 bits. Rate = state[127:0]; capacity key XOR = state[255:128] … as per the `ascon_pack` word layout.
- `p^a` = 12 rounds; `p^b` = 8 rounds. Each PERM state takes 12/`UNROLL` or 8/`UNROLL` cycles.

FSM states:
- **IDLE**: `start_i` = 1 loads IV‖K‖N, latches inputs and goes to INIT.
- **INIT**: `p^a`, then XOR K into the low 256-bit words. Next state is AD_WAIT if `nb_ad` > 0, else DOMSEP.
- **AD_WAIT**: `data_ready_o` = 1. On handshake, rate ^= `data_i` → AD_PERM (`p^b`). After each block, return to AD_WAIT while the AD count remaining is > 0. After the last block: rate ^= `PAD_FULL`, then AD_PAD_PERM (`p^b`), then DOMSEP.
- **DOMSEP**: single cycle; state[0] ^= 1. Next state is DATA_WAIT if `nb_data` > 0, else FINAL.
- **DATA_WAIT**: `data_ready_o` = 1. On handshake:
  - Encrypt: `data_o` = rate ^ `data_i`, and rate = that value.
  - Decrypt: `data_o` = rate ^ `data_i`, and rate = `data_i`.
  - Then go to DATA_PERM (`p^b`). Return to DATA_WAIT while data blocks remain; otherwise go to FINAL.
- **FINAL**: on entry, rate ^= `PAD_FULL` and XOR K into the capacity words adjacent to the rate; then `p^a`.
- **TAG**: single cycle. `tag_o` = state[319:192] ^ K. `tag_valid_o` pulses. `auth_ok_o` is set by the compare in decrypt.
- **DONE**: one cycle; `busy_o` drops on exit to IDLE.

Block counters:
- Loaded at start and decremented on each accepted block.
- No wrap: the zero test gates the phase exit.

## Timing

- Reset values: all outputs 0, FSM in IDLE, state register 0. Reset mid-operation aborts immediately; no pulse is emitted after reset release.
- Start is sampled at edge S; `busy_o` = 1 from S+1.
- INIT occupies 12/`UNROLL` cycles.
- `data_ready_o` is combinational from the FSM state only; it never depends on `data_valid_i`.
- `data_o` and `data_valid_o` are registered one cycle after the handshake edge.
- Per-block throughput is 1 + 8/`UNROLL` cycles with `data_valid_i` held high.
- `tag_valid_o` rises 1 cycle after the last FINAL round. `busy_o` falls 1 cycle later.
- `start_i` while busy is ignored.
- `data_valid_i` outside the WAIT states is ignored; no block is consumed.
- `decrypt_i`, `key_i`, `nonce_i`, `tag_i` and the counts may change after S without effect.

## Test plan

- **Encrypt, `UNROLL`=1, `nb_ad`=1, `nb_data`=1, all-zero key/nonce/data:**
  - `data_o` must match the software reference ciphertext, and `tag_o` the reference tag.
  - Start → `tag_valid_o` must equal 1 + 12 + 9 + 8 + 1 + 9 + 12 + 1 cycles (±0).
- **Round trip:**
  - Decrypt the previous ciphertext with the tag from that run: plaintext must be 0 and `auth_ok_o` = 1.
  - Flip `tag_i[0]`: `auth_ok_o` = 0 while the plaintext is still identical.
- **Zero-count cases:**
  - `nb_ad`=0, `nb_data`=0: no `data_ready_o` assertion at all, and `tag_o` matches the reference.
  - `nb_ad`=3, `nb_data`=0: exactly three handshakes.
- **Unrolling and back-pressure:**
  - `UNROLL`=2 and `UNROLL`=4 with `nb_ad`=2, `nb_data`=4 and random key/nonce/data: outputs must be bit-identical to `UNROLL`=1.
  - Latency scales as 6/4 and 3/2 cycles per `p^a`/`p^b`.
  - With `data_valid_i` randomly deasserted, results are unchanged and there are no extra `data_valid_o` pulses.
- **Reset and ignored inputs:**
  - Assert `resetb_i` low during DATA_PERM: all outputs go to 0 immediately.
  - A new start after release produces the correct results.
  - A `start_i` pulse mid-run is ignored.
